// File: rtl/pwm_guard_multi.sv
// N-channel full-bridge PWM protection gate; PWM path is combinational, while the enables and lockout are registered one clock after flt_n. No backpressure: inputs are always accepted.
// Define PWM_GUARD_DEADTIME_EN to add a DT_CYC-clock rising-edge delay on every gated output.
module pwm_guard_multi #(
   parameter int N_CH      = 2,
   parameter int LS_DELAY  = 150,
   parameter int CNT_W     = 8,
   parameter int RETRY_MAX = 3,
   parameter int DT_CYC    = 25
) (
   input  logic              CLK_50M,
   input  logic              Rst_n,
   input  logic [4*N_CH-1:0] pwm_in,
   input  logic [N_CH-1:0]   flt_n,
   input  logic              reset_req,
   output logic [4*N_CH-1:0] pwm_out,
   output logic [N_CH-1:0]   en_hi,
   output logic [N_CH-1:0]   en_lo,
   output logic [N_CH-1:0]   lockout,
   output logic [4*N_CH-1:0] trip_cnt
);

   typedef enum logic [1:0] {NORMAL, TRIP, LOCK} state_t;

   localparam logic [CNT_W-1:0] LS_MAX = CNT_W'(LS_DELAY);
   localparam logic [4:0]       RETRY  = 5'(RETRY_MAX);

   logic [4*N_CH-1:0] gated;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      state_t           state, state_nxt;
      logic [3:0]       cnt, cnt_nxt;
      logic [1:0]       s1, s2;
      logic             rise, blk;
      logic             ll, lh, rl, rh;
      logic             hi_nxt, lock_nxt;
      logic             hi_q, lo_q, lock_q;
      logic [CNT_W-1:0] ls_cnt;

      assign {rh, rl, lh, ll} = pwm_in[4*k +: 4];
      assign rise = |(s1 & ~s2);
      assign blk  = (ll & lh) | (rl & rh);

      always_ff @(posedge CLK_50M) begin
         if (!Rst_n) begin
            state <= NORMAL;
            cnt   <= '0;
            s1    <= '0;
            s2    <= '0;
         end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            s1    <= {rh, lh};
            s2    <= s1;
         end
      end

      // Case order gives the priority: a fault in NORMAL beats reset_req.
      always_comb begin
         state_nxt = state;
         cnt_nxt   = cnt;
         case (state)
            NORMAL: if (!flt_n[k]) begin
               state_nxt = (({1'b0, cnt} + 5'd1) >= RETRY) ? LOCK : TRIP;
               cnt_nxt   = (cnt == 4'hF) ? cnt : cnt + 4'd1;
            end
            TRIP: if (flt_n[k]) begin
               if (reset_req) begin
                  state_nxt = NORMAL;
                  cnt_nxt   = '0;
               end else if (rise) begin
                  state_nxt = NORMAL;
               end
            end
            LOCK: if (flt_n[k] && reset_req) begin
               state_nxt = NORMAL;
               cnt_nxt   = '0;
            end
            default: state_nxt = NORMAL;
         endcase
      end

      always_comb begin
         hi_nxt   = (state_nxt == NORMAL);
         lock_nxt = (state_nxt == LOCK);
      end

      // Low side stays on LS_DELAY clocks after the high side drops, so a quick recovery never toggles it.
      always_ff @(posedge CLK_50M) begin
         if (!Rst_n) begin
            hi_q   <= 1'b0;
            lo_q   <= 1'b0;
            lock_q <= 1'b0;
            ls_cnt <= '0;
         end else begin
            hi_q   <= hi_nxt;
            lock_q <= lock_nxt;
            lo_q   <= (ls_cnt != LS_MAX);
            if (hi_q)
               ls_cnt <= '0;
            else if (ls_cnt != LS_MAX)
               ls_cnt <= ls_cnt + CNT_W'(1);
         end
      end

      assign en_hi[k]           = hi_q;
      assign en_lo[k]           = lo_q;
      assign lockout[k]         = lock_q;
      assign trip_cnt[4*k +: 4] = cnt;
      assign gated[4*k +: 4]    = {rh & hi_q, rl & lo_q, lh & hi_q, ll & lo_q} & {4{~blk & Rst_n}};
   end

`ifdef PWM_GUARD_DEADTIME_EN
   localparam int             DT_W   = $clog2(DT_CYC + 1);
   localparam logic [DT_W-1:0] DT_MAX = DT_W'(DT_CYC);

   for (genvar b = 0; b < 4*N_CH; b++) begin : g_dt
      logic [DT_W-1:0] dt_cnt;

      always_ff @(posedge CLK_50M) begin
         if (!Rst_n || !gated[b])
            dt_cnt <= '0;
         else if (dt_cnt != DT_MAX)
            dt_cnt <= dt_cnt + DT_W'(1);
      end

      assign pwm_out[b] = gated[b] & (dt_cnt == DT_MAX);
   end
`else
   assign pwm_out = gated;
`endif

endmodule
